lsu_mem_master: RTL and testbench

- Initiator side of the data-memory port: accepts one load/store from the EXU/LSU pipeline stage and drives the doubleword memory responder (addr/ce/we/wdata/wmask/rdata).
- Aligns the address, builds the byte mask, lane-shifts store data, and sign- or zero-extends load data.
- Runs a small FSM with a programmable wait count, then holds the response until the pipeline accepts it.
- Sits between the execute stage and the DPI-backed memory model.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_mem_master_if.sv | 32 +++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_master.sv | 122 ++++++++++++
 tb/tb_lsu_mem_master.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory master: funct3 encodings,
// FSM state encoding and access-size helper functions.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Byte-enable pattern for an access of 1/2/4/8 bytes, right-aligned.
  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_to_align(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Bundle of the pipeline request/response handshake and the doubleword
// memory port. master = the LSU, slave = pipeline + memory model side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic        mem_ce;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed bytes of a doubleword down to
// bit 0 and sign/zero-extends according to funct3. Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_data
);

  logic [63:0] w_raw;
  assign w_raw = i_rdata >> {i_off, 3'b000};

  // Extension by access type; op 111 falls through to the D (raw) case.
  always_comb begin
    o_data = w_raw;
    case (i_op)
      LSU_B:   o_data = {{56{w_raw[7]}},  w_raw[7:0]};
      LSU_H:   o_data = {{48{w_raw[15]}}, w_raw[15:0]};
      LSU_W:   o_data = {{32{w_raw[31]}}, w_raw[31:0]};
      LSU_BU:  o_data = {56'd0, w_raw[7:0]};
      LSU_HU:  o_data = {48'd0, w_raw[15:0]};
      LSU_WU:  o_data = {32'd0, w_raw[31:0]};
      default: o_data = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// LSU data-memory initiator: one outstanding load/store, IDLE -> ACCESS
// (WAIT_CYCLES+1 cycles of mem_ce) -> RESP (held until resp_ready).
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned requests skip ACCESS
// and complete with resp_err=1; otherwise resp_err is tied 0.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned XLEN        = 64
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_master_if.master  bus
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  lsu_state_e       r_state, w_next;
  logic [3:0]       r_cnt;
  logic             r_we;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_addr;
  logic [XLEN-1:0]  r_wdata;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  w_load;
  logic [2:0]       w_off;
  logic             w_mis;

  assign w_off = r_addr[2:0];

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_err;
  assign w_mis        = |(bus.req_addr[2:0] & size_to_align(bus.req_op[1:0]));
  assign bus.resp_err = (r_state == ST_RESP) && r_err;
`else
  assign w_mis        = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  lsu_load_align u_align (
    .i_op    (r_op),
    .i_off   (w_off),
    .i_rdata (bus.mem_rdata),
    .o_data  (w_load)
  );

  // State register; async reset drops mem_ce immediately, even mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and outputs; memory signals come only from latched fields.
  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_ce     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wmask  = '0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = w_mis ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.mem_ce   = 1'b1;
        bus.mem_we   = r_we;
        bus.mem_addr = {r_addr[XLEN-1:3], 3'b000};
        if (r_we) begin
          bus.mem_wmask = size_to_mask(r_op[1:0]) << w_off;
          bus.mem_wdata = r_wdata << {w_off, 3'b000};
        end
        if (r_cnt == 4'd0) w_next = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_rdata;
        if (bus.resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (bus.req_valid) begin
          r_we    <= bus.req_we;
          r_op    <= bus.req_op;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_cnt   <= LP_WAIT;
`ifdef LSU_MISALIGN_CHECK_EN
          r_rdata <= '0;
          r_err   <= w_mis;
`endif
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) r_rdata <= r_we ? '0 : w_load;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master: dut0 (WAIT_CYCLES=0)
// and dut3 (WAIT_CYCLES=3) share the clock, with independent resets.
`timescale 1ns/1ps
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if bus0 ();
  lsu_mem_master_if bus3 ();

  lsu_mem_master #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  lsu_mem_master #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  // Present a request on dut0 for one accept edge; returns at edge+1.
  task automatic issue0(input logic we, input logic [2:0] op,
                        input logic [63:0] addr, input logic [63:0] wd);
    bus0.req_we = we; bus0.req_op = op; bus0.req_addr = addr;
    bus0.req_wdata = wd; bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
  endtask

  task automatic consume0();
    bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (bus0.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", bus0.req_ready); end
    n_vec++; if (bus0.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b want 0", bus0.resp_valid); end
    n_vec++; if (bus0.mem_ce !== 1'b0 || bus0.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_ce_we got %b%b want 00", bus0.mem_ce, bus0.mem_we); end
    n_vec++; if (bus0.mem_wmask !== 8'h00 || bus0.mem_addr !== 64'h0 || bus0.mem_wdata !== 64'h0) begin n_err++; $display("FAIL rst_mem_bus got %h/%h/%h want 0", bus0.mem_wmask, bus0.mem_addr, bus0.mem_wdata); end
    n_vec++; if (bus0.resp_rdata !== 64'h0 || bus0.resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp got %h/%b want 0", bus0.resp_rdata, bus0.resp_err); end
    n_vec++; if (bus3.req_ready !== 1'b1 || bus3.mem_ce !== 1'b0) begin n_err++; $display("FAIL rst3 got ready=%b ce=%b want 1/0", bus3.req_ready, bus3.mem_ce); end
  endtask

  task automatic test_ld();
    bus0.mem_rdata = 64'h1122334455667788;
    issue0(1'b0, 3'b011, 64'h80000008, 64'h0);
    n_vec++; if (bus0.mem_ce !== 1'b1 || bus0.mem_we !== 1'b0) begin n_err++; $display("FAIL ld_ce_we got %b%b want 10", bus0.mem_ce, bus0.mem_we); end
    n_vec++; if (bus0.mem_addr !== 64'h80000008) begin n_err++; $display("FAIL ld_addr got %h want 80000008", bus0.mem_addr); end
    n_vec++; if (bus0.mem_wmask !== 8'h00) begin n_err++; $display("FAIL ld_wmask got %h want 00", bus0.mem_wmask); end
    n_vec++; if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b0) begin n_err++; $display("FAIL ld_access_hs got v=%b r=%b want 0/0", bus0.resp_valid, bus0.req_ready); end
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_valid !== 1'b1 || bus0.mem_ce !== 1'b0) begin n_err++; $display("FAIL ld_resp_timing got v=%b ce=%b want 1/0", bus0.resp_valid, bus0.mem_ce); end
    n_vec++; if (bus0.resp_rdata !== 64'h1122334455667788) begin n_err++; $display("FAIL ld_rdata got %h want 1122334455667788", bus0.resp_rdata); end
    consume0();
    n_vec++; if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin n_err++; $display("FAIL ld_idle got v=%b r=%b want 0/1", bus0.resp_valid, bus0.req_ready); end
  endtask

  task automatic test_lb_lbu();
    bus0.mem_rdata = 64'h0000000080000000;
    issue0(1'b0, 3'b000, 64'h80000003, 64'h0);
    n_vec++; if (bus0.mem_addr !== 64'h80000000) begin n_err++; $display("FAIL lb_addr got %h want 80000000", bus0.mem_addr); end
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_rdata !== 64'hFFFFFFFFFFFFFF80) begin n_err++; $display("FAIL lb_rdata got %h want FFFFFFFFFFFFFF80", bus0.resp_rdata); end
    consume0();
    issue0(1'b0, 3'b100, 64'h80000003, 64'h0);
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_rdata !== 64'h0000000000000080) begin n_err++; $display("FAIL lbu_rdata got %h want 0000000000000080", bus0.resp_rdata); end
    consume0();
  endtask

  task automatic test_store();
    bus0.mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    issue0(1'b1, 3'b001, 64'h80000006, 64'h000000000000ABCD);
    n_vec++; if (bus0.mem_wmask !== 8'hC0) begin n_err++; $display("FAIL sh_wmask got %h want C0", bus0.mem_wmask); end
    n_vec++; if (bus0.mem_wdata !== 64'hABCD000000000000) begin n_err++; $display("FAIL sh_wdata got %h want ABCD000000000000", bus0.mem_wdata); end
    n_vec++; if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 64'h80000000) begin n_err++; $display("FAIL sh_we_addr got %b/%h want 1/80000000", bus0.mem_we, bus0.mem_addr); end
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 64'h0) begin n_err++; $display("FAIL sh_resp got v=%b d=%h want 1/0", bus0.resp_valid, bus0.resp_rdata); end
    consume0();
    // SW at offset 4: mask 0F<<4, data shifted by 32 bits
    issue0(1'b1, 3'b010, 64'h80000014, 64'hFFFFFFFF12345678);
    n_vec++; if (bus0.mem_wmask !== 8'hF0 || bus0.mem_wdata !== 64'h1234567800000000) begin n_err++; $display("FAIL sw_bus got %h/%h want F0/1234567800000000", bus0.mem_wmask, bus0.mem_wdata); end
    @(posedge clk); #1;
    consume0();
  endtask

  task automatic test_backpressure();
    logic ok;
    ok = 1'b1;
    bus0.mem_rdata = 64'h8765432100000000;
    issue0(1'b0, 3'b010, 64'h80000004, 64'h0);
    @(posedge clk); #1;
    bus0.mem_rdata = 64'h0;
    bus0.req_valid = 1'b1;  // must not be accepted while busy
    for (int i = 0; i < 5; i++) begin
      if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 64'hFFFFFFFF87654321 || bus0.req_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    bus0.req_valid = 1'b0;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_hold got v=%b d=%h r=%b want 1/FFFFFFFF87654321/0", bus0.resp_valid, bus0.resp_rdata, bus0.req_ready); end
    consume0();
    n_vec++; if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got v=%b r=%b want 0/1", bus0.resp_valid, bus0.req_ready); end
  endtask

  task automatic test_back_to_back();
    bus0.mem_rdata = 64'h00000000F00D0000;
    bus0.req_we = 1'b0; bus0.req_op = 3'b101; bus0.req_addr = 64'h80000002;
    bus0.req_valid = 1'b1; bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.req_op = 3'b001;
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_rdata !== 64'h000000000000F00D || bus0.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_lhu got %h r=%b want 000000000000F00D/0", bus0.resp_rdata, bus0.req_ready); end
    @(posedge clk); #1;
    n_vec++; if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0 || bus0.mem_ce !== 1'b0) begin n_err++; $display("FAIL b2b_gap got r=%b v=%b ce=%b want 1/0/0", bus0.req_ready, bus0.resp_valid, bus0.mem_ce); end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    n_vec++; if (bus0.mem_ce !== 1'b1) begin n_err++; $display("FAIL b2b_second_ce got %b want 1", bus0.mem_ce); end
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_rdata !== 64'hFFFFFFFFFFFFF00D) begin n_err++; $display("FAIL b2b_lh got %h want FFFFFFFFFFFFF00D", bus0.resp_rdata); end
    @(posedge clk); #1;
    bus0.resp_ready = 1'b0;
  endtask

  task automatic test_wait3();
    int ce_cnt, first;
    logic ok;
    ce_cnt = 0; first = 0; ok = 1'b1;
    bus3.mem_rdata = 64'hDEADBEEFCAFEF00D;
    bus3.req_we = 1'b0; bus3.req_op = 3'b011; bus3.req_addr = 64'h80000010;
    bus3.req_wdata = 64'h0; bus3.req_valid = 1'b1; bus3.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (bus3.mem_ce === 1'b1) ce_cnt++;
      if (bus3.resp_valid === 1'b1 && first == 0) first = i;
      @(posedge clk); #1;
    end
    n_vec++; if (ce_cnt != 4) begin n_err++; $display("FAIL w3_ce_cycles got %0d want 4", ce_cnt); end
    n_vec++; if (first != 5) begin n_err++; $display("FAIL w3_resp_latency got %0d want 5", first); end
    n_vec++; if (bus3.resp_rdata !== 64'hDEADBEEFCAFEF00D) begin n_err++; $display("FAIL w3_rdata got %h want DEADBEEFCAFEF00D", bus3.resp_rdata); end
    bus3.resp_ready = 1'b1; @(posedge clk); #1; bus3.resp_ready = 1'b0;
    // reset in the second ACCESS cycle
    bus3.req_valid = 1'b1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus3.mem_ce !== 1'b1) begin n_err++; $display("FAIL w3_pre_rst_ce got %b want 1", bus3.mem_ce); end
    #2 rst3 = 1'b1;
    #1;
    n_vec++; if (bus3.mem_ce !== 1'b0 || bus3.req_ready !== 1'b1) begin n_err++; $display("FAIL w3_async_rst got ce=%b r=%b want 0/1", bus3.mem_ce, bus3.req_ready); end
    @(posedge clk); #3 rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus3.resp_valid !== 1'b0 || bus3.mem_ce !== 1'b0 || bus3.req_ready !== 1'b1) ok = 1'b0;
    end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL w3_no_retry got v=%b ce=%b r=%b want 0/0/1", bus3.resp_valid, bus3.mem_ce, bus3.req_ready); end
  endtask

  task automatic test_misalign();
    bus0.mem_rdata = 64'h1122334455667788;
    issue0(1'b0, 3'b010, 64'h80000002, 64'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    n_vec++; if (bus0.mem_ce !== 1'b0) begin n_err++; $display("FAIL mis_ce got %b want 0", bus0.mem_ce); end
    n_vec++; if (bus0.resp_valid !== 1'b1 || bus0.resp_err !== 1'b1 || bus0.resp_rdata !== 64'h0) begin n_err++; $display("FAIL mis_resp got v=%b e=%b d=%h want 1/1/0", bus0.resp_valid, bus0.resp_err, bus0.resp_rdata); end
`else
    n_vec++; if (bus0.mem_ce !== 1'b1 || bus0.mem_wmask !== 8'h00 || bus0.mem_addr !== 64'h80000000) begin n_err++; $display("FAIL mis_access got ce=%b m=%h a=%h want 1/00/80000000", bus0.mem_ce, bus0.mem_wmask, bus0.mem_addr); end
    @(posedge clk); #1;
    n_vec++; if (bus0.resp_valid !== 1'b1 || bus0.resp_err !== 1'b0 || bus0.resp_rdata !== 64'h0000000033445566) begin n_err++; $display("FAIL mis_resp got v=%b e=%b d=%h want 1/0/0000000033445566", bus0.resp_valid, bus0.resp_err, bus0.resp_rdata); end
`endif
    consume0();
    n_vec++; if (bus0.req_ready !== 1'b1 || bus0.resp_err !== 1'b0) begin n_err++; $display("FAIL mis_idle got r=%b e=%b want 1/0", bus0.req_ready, bus0.resp_err); end
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_op = 3'b0;
    bus0.req_addr = 64'h0; bus0.req_wdata = 64'h0; bus0.resp_ready = 1'b0;
    bus0.mem_rdata = 64'h0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_op = 3'b0;
    bus3.req_addr = 64'h0; bus3.req_wdata = 64'h0; bus3.resp_ready = 1'b0;
    bus3.mem_rdata = 64'h0;
    #12;
    test_reset();
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
    test_ld();
    test_lb_lbu();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_wait3();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
